// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: sync, data-enable and position
// for the 1280x720 output path, all registered on pixel_clk.
module video_timing_gen #(
  parameter int   hWidth       = 1280,
  parameter int   hFrontPorch  = 72,
  parameter int   hSyncWidth   = 80,
  parameter int   hBackPorch   = 216,
  parameter int   vWidth       = 720,
  parameter int   vFrontPorch  = 3,
  parameter int   vSyncWidth   = 5,
  parameter int   vBackPorch   = 22,
  parameter logic HSYNC_ACTIVE = 1'b1,
  parameter logic VSYNC_ACTIVE = 1'b1,
  parameter int   FRAME_CNT_W  = 16,
  localparam int  H_TOTAL = hWidth + hFrontPorch + hSyncWidth + hBackPorch,
  localparam int  V_TOTAL = vWidth + vFrontPorch + vSyncWidth + vBackPorch,
  localparam int  HW      = $clog2(H_TOTAL),
  localparam int  VW      = $clog2(V_TOTAL)
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [HW-1:0]          h_pos,
  output logic [VW-1:0]          v_pos,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  if (hWidth < 1 || hFrontPorch < 1 || hSyncWidth < 1 ||
      hBackPorch < 1 || vWidth < 1 || vFrontPorch < 1 ||
      vSyncWidth < 1 || vBackPorch < 1 || FRAME_CNT_W < 1) begin : g_bad
    $error("video_timing_gen: every timing width must be >= 1");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(hWidth);
  localparam logic [HW-1:0] H_SS   = HW'(hWidth + hFrontPorch);
  localparam logic [HW-1:0] H_SE   = HW'(hWidth + hFrontPorch + hSyncWidth);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(vWidth);
  localparam logic [VW-1:0] V_SS   = VW'(vWidth + vFrontPorch);
  localparam logic [VW-1:0] V_SE   = VW'(vWidth + vFrontPorch + vSyncWidth);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_nxt;
  logic          first;

  // Flags decode the next position so they register alongside it.
  always_comb begin
    h_wrap = (h_pos == H_LAST);
    v_wrap = h_wrap && (v_pos == V_LAST);
    h_nxt  = h_wrap ? '0 : h_pos + HW'(1);
    v_nxt  = v_pos;
    if (h_wrap) begin
      v_nxt = (v_pos == V_LAST) ? '0 : v_pos + VW'(1);
    end
    de_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt = (h_nxt >= H_SS) && (h_nxt < H_SE);
    vs_nxt = (v_nxt >= V_SS) && (v_nxt < V_SE);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pos       <= H_LAST;
      v_pos       <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~HSYNC_ACTIVE;
      vsync       <= ~VSYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      first       <= 1'b1;
    end else if (en) begin
      h_pos       <= h_nxt;
      v_pos       <= v_nxt;
      de          <= de_nxt;
      hsync       <= hs_nxt ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync       <= vs_nxt ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap) begin
        first <= 1'b0;
        // frame 0 after reset is not a completed frame
        if (!first) begin
          frame_count <= frame_count + FRAME_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: small raster (both sync
// polarities) plus the default 1280x720 raster, driven in lockstep.
module tb_video_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [4:0] s_h;
  logic [3:0] s_v;
  logic [2:0] s_fc;
  logic       n_hs, n_vs, n_de, n_ls, n_fs;
  logic [4:0] n_h;
  logic [3:0] n_v;
  logic [2:0] n_fc;
  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [10:0] b_h;
  logic [9:0]  b_v;
  logic [15:0] b_fc;

  video_timing_gen #(
    .hWidth(8), .hFrontPorch(2), .hSyncWidth(3), .hBackPorch(4),
    .vWidth(4), .vFrontPorch(1), .vSyncWidth(2), .vBackPorch(3),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1), .FRAME_CNT_W(3)
  ) dut_s (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .h_pos(s_h), .v_pos(s_v),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  video_timing_gen #(
    .hWidth(8), .hFrontPorch(2), .hSyncWidth(3), .hBackPorch(4),
    .vWidth(4), .vFrontPorch(1), .vSyncWidth(2), .vBackPorch(3),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .FRAME_CNT_W(3)
  ) dut_n (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
    .hsync(n_hs), .vsync(n_vs), .de(n_de), .h_pos(n_h), .v_pos(n_v),
    .line_start(n_ls), .frame_start(n_fs), .frame_count(n_fc)
  );

  video_timing_gen dut_b (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .h_pos(b_h), .v_pos(b_v),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  typedef struct {
    int h, v, fc, nfs;
    bit hs, vs, de, ls, fs;
  } exp_t;

  typedef struct {
    exp_t s;
    exp_t b;
  } item_t;

  item_t q[$];
  item_t mon_it;
  exp_t  ms, mb;
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t rst_exp(int ht, int vt);
    exp_t e = '{default: 0};
    e.h = ht - 1;
    e.v = vt - 1;
    return e;
  endfunction

  function automatic exp_t adv(exp_t e, int hw, int hfp, int hsw, int hbp,
                               int vw, int vfp, int vsw, int vbp, int fcw);
    int ht = hw + hfp + hsw + hbp;
    int vt = vw + vfp + vsw + vbp;
    e.ls = (e.h == ht - 1);
    e.h  = e.ls ? 0 : e.h + 1;
    if (e.ls) e.v = (e.v == vt - 1) ? 0 : e.v + 1;
    e.fs = e.ls && (e.v == 0);
    if (e.fs) e.nfs++;
    e.fc = (e.nfs > 0) ? (e.nfs - 1) % (1 << fcw) : 0;
    e.de = (e.h < hw) && (e.v < vw);
    e.hs = (e.h >= hw + hfp) && (e.h < hw + hfp + hsw);
    e.vs = (e.v >= vw + vfp) && (e.v < vw + vfp + vsw);
    return e;
  endfunction

  function automatic logic [52:0] pk(int h, int v, int fc,
                                     logic hs, logic vs, logic de,
                                     logic ls, logic fs);
    return {fc[15:0], v[15:0], h[15:0], hs, vs, de, ls, fs};
  endfunction

  function automatic logic [52:0] pke(exp_t e);
    return pk(e.h, e.v, e.fc, e.hs, e.vs, e.de, e.ls, e.fs);
  endfunction

  task automatic cmp(string name, logic [52:0] got, logic [52:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s at %0t: got fc/v/h/flags %h required %h",
                 name, $time, got, want);
    end
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Directed measurements on the first line of the full-size raster.
  bit         meas = 1'b0;
  int         de_cnt = 0;
  int         hs_cnt = 0;
  int         rise_h = -1;
  logic [10:0] prev_bh = '0;
  logic        prev_bhs = 1'b0;

  always @(negedge pixel_clk) begin
    if (q.size() > 0) begin
      mon_it = q.pop_front();
      cmp("small", pk(s_h, s_v, s_fc, s_hs, s_vs, s_de, s_ls, s_fs),
          pke(mon_it.s));
      cmp("inverted", pk(n_h, n_v, n_fc, ~n_hs, ~n_vs, n_de, n_ls, n_fs),
          pke(mon_it.s));
      cmp("full", pk(b_h, b_v, b_fc, b_hs, b_vs, b_de, b_ls, b_fs),
          pke(mon_it.b));
    end
    if (meas && b_h != prev_bh && b_v == 0) begin
      if (b_de) de_cnt++;
      if (b_hs) hs_cnt++;
      if (b_hs && !prev_bhs) rise_h = b_h;
    end
    prev_bh  = b_h;
    prev_bhs = b_hs;
  end

  task automatic step();
    logic r, e;
    @(posedge pixel_clk);
    r = rst_n;
    e = en;
    #1;
    if (r && e) begin
      ms = adv(ms, 8, 2, 3, 4, 4, 1, 2, 3, 3);
      mb = adv(mb, 1280, 72, 80, 216, 720, 3, 5, 22, 16);
    end
    q.push_back(item_t'{ms, mb});
  endtask

  // Reset lands between edges; the compare happens before any edge.
  task automatic async_reset();
    @(posedge pixel_clk);
    #2 rst_n = 1'b0;
    #1;
    ms = rst_exp(17, 10);
    mb = rst_exp(1648, 750);
    q.push_back(item_t'{ms, mb});
  endtask

  initial begin
    ms = rst_exp(17, 10);
    mb = rst_exp(1648, 750);
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    meas = 1'b1;
    repeat (501) step();
    en = 1'b0;
    repeat (100) step();
    en = 1'b1;
    repeat (1400) step();
    meas = 1'b0;
    repeat (7) step();
    async_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (200) step();
    @(negedge pixel_clk);
    #1;
    chk("de_cycles_line0", de_cnt, 1280);
    chk("hsync_width", hs_cnt, 80);
    chk("hsync_rise_h", rise_h, 1352);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing generator that produces hsync, vsync, data-enable and raster position for the 1280x720 output path.
- Sits directly upstream of the camera ray generator, which consumes hsync/vsync on the same pixel_clk.
- Also feeds the pixel output stage, which uses de, h_pos and v_pos.
- Sync rising edges must land exactly on the first sync-pulse pixel/line. The downstream stage realigns its own counters to hWidth+hFrontPorch and vWidth+vFrontPorch on those edges.

Parameters:
- hWidth, 1280, active pixels per line
- hFrontPorch, 72, pixels from end of active to hsync start
- hSyncWidth, 80, hsync pulse width in pixels
- hBackPorch, 216, pixels from hsync end to next line
- vWidth, 720, active lines per frame
- vFrontPorch, 3, lines from end of active to vsync start
- vSyncWidth, 5, vsync pulse width in lines
- vBackPorch, 22, lines from vsync end to next frame
- HSYNC_ACTIVE, 1, asserted level of hsync
- VSYNC_ACTIVE, 1, asserted level of vsync
- FRAME_CNT_W, 16, width of frame counter

Ports:
- pixel_clk  input  1  pixel clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  advance raster when high; hold all state when low
- hsync  output  1  horizontal sync, level per HSYNC_ACTIVE
- vsync  output  1  vertical sync, level per VSYNC_ACTIVE
- de  output  1  high during active pixels
- h_pos  output  clog2(hTotal)  current horizontal position
- v_pos  output  clog2(vTotal)  current vertical position
- line_start  output  1  one-cycle pulse at h_pos==0
- frame_start  output  1  one-cycle pulse at h_pos==0 && v_pos==0
- frame_count  output  FRAME_CNT_W  completed-frame counter

Behaviour:
- Totals: hTotal = sum of all h parameters (1648); vTotal = sum of all v parameters (750).
- All outputs are registers and describe the same raster position. hsync, vsync, de and the pulses are decoded from the next-state counter values, so there is no skew between h_pos/v_pos and the flags.
- Reset (rst_n low, takes effect immediately):
  - h_pos=hTotal-1, v_pos=vTotal-1 (last back-porch pixel)
  - de=0, hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE
  - line_start=0, frame_start=0, frame_count=0
- First enabled edge after reset moves to (0,0) with de=1, line_start=1, frame_start=1.
- Counting per enabled edge:
  - h_pos increments and wraps from hTotal-1 to 0.
  - v_pos increments only when h_pos wraps, and wraps from vTotal-1 to 0.
- de = (h_pos < hWidth) && (v_pos < vWidth).
- hsync is asserted iff hWidth+hFrontPorch <= h_pos < hWidth+hFrontPorch+hSyncWidth, i.e. h_pos 1352..1431.
- vsync is asserted iff vWidth+vFrontPorch <= v_pos < vWidth+vFrontPorch+vSyncWidth, i.e. v_pos 723..727 inclusive of all h_pos on those lines.
  - vsync changes only together with h_pos going to 0.
- frame_count increments, wrapping at 2^FRAME_CNT_W, on the same edge frame_start asserts, except the first frame after reset.
  - Result: frame_count is 0 throughout frame 0 and reads N during frame N.
- en low: every register holds, including the pulses. A pulse that was high stays high and is not re-issued when en returns high.
  - Consumers gate pulses with en.
- Simultaneous end-of-line and end-of-frame: h_pos and v_pos wrap on the same edge; frame_start and line_start both assert.
- Reset mid-frame: immediate return to reset state; the next frame starts cleanly at (0,0).
- Parameter legality: all widths >= 1. Violations are elaboration-time errors via a generate-time check.

Test Plan:
- Reset release, en=1 -> cycle 1: h_pos=0, v_pos=0, de=1, frame_start=1, line_start=1, frame_count=0. Cycle 2: frame_start=0, line_start=0.
- Run one line -> de high for exactly 1280 cycles. hsync rises at h_pos=1352, falls at h_pos=1432, is 80 cycles wide. line_start recurs every 1648 cycles.
- Run one frame -> vsync rises with h_pos=0, v_pos=723; stays high 5*1648=8240 cycles. frame_start recurs every 1,236,000 cycles; frame_count=1 in frame 1.
- Toggle en low for 100 cycles mid-line at h_pos=500 -> all outputs frozen. On resume, h_pos=501 next edge; total frame period extended by exactly 100 cycles.
- Set HSYNC_ACTIVE=0, VSYNC_ACTIVE=0 -> sync waveforms are exact inversions of the default run; de and positions are unchanged.
- Assert rst_n low at v_pos=400, h_pos=900 for 3 cycles -> outputs go to reset values asynchronously. Release gives (0,0) with frame_start=1 and frame_count=0.
